framebuffer_fill_engine: RTL

- Bus initiator that fills rectangles of the VGA framebuffer with a solid 8-bit colour, issuing word writes with byte enables toward the framebuffer's bus responder port.
- Sits beside the core on the data bus behind an arbiter: it requests the bus, and each write completes in any cycle where the grant is high.
- Offloads screen clears and box drawing from software.
- Framebuffer layout: 320x240, 1 byte per pixel, 4 pixels per 32-bit word, little-endian, so pixel x=4w+k is byte k.

---
 rtl/framebuffer_fill_engine.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/framebuffer_fill_engine.sv
// Solid-colour rectangle fill engine: clips a rectangle to the 320x240 frame and
// issues one 32-bit byte-enabled write per covered word toward the framebuffer.
module framebuffer_fill_engine #(
  parameter logic [31:0] FB_BASE      = 32'hFF00_0000,
  parameter logic [31:0] FRAME_OFFSET = 32'h0010_0000,
  parameter int          H_RES        = 320,
  parameter int          V_RES        = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [8:0]  cmd_width,
  input  logic [7:0]  cmd_height,
  input  logic [7:0]  cmd_color,
  input  logic        cmd_frame,
  output logic        busy,
  output logic        done,
  output logic        bus_request,
  input  logic        bus_grant,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_write_enable
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [8:0] w_q, w_d;
  logic [7:0] h_q, h_d;
  logic [7:0] color_q, color_d;
  logic       frame_q, frame_d;
  logic [9:0] xe_q, xe_d;
  logic [9:0] ye_q, ye_d;
  logic [7:0] line_q, line_d;
  logic [6:0] word_q, word_d;

  logic [9:0] x_end, y_end, xe_calc, ye_calc;
  logic       empty_rect;

  // Clip against the frame edges at 10 bits so x+width never wraps.
  always_comb begin
    x_end      = {1'b0, x_q} + {1'b0, w_q};
    y_end      = {2'b00, y_q} + {2'b00, h_q};
    xe_calc    = ((x_end > 10'(H_RES)) ? 10'(H_RES) : x_end) - 10'd1;
    ye_calc    = ((y_end > 10'(V_RES)) ? 10'(V_RES) : y_end) - 10'd1;
    empty_rect = (w_q == 9'd0) || (h_q == 8'd0) ||
                 ({1'b0, x_q} >= 10'(H_RES)) || ({2'b00, y_q} >= 10'(V_RES));
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    frame_d = frame_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    line_d  = line_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_width;
          h_d     = cmd_height;
          color_d = cmd_color;
          frame_d = cmd_frame;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        xe_d    = xe_calc;
        ye_d    = ye_calc;
        line_d  = y_q;
        word_d  = x_q[8:2];
        state_d = empty_rect ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        // The presented write retires only in a granted cycle; otherwise hold.
        if (bus_grant) begin
          if ({1'b0, word_q} < xe_q[9:2]) begin
            word_d = word_q + 7'd1;
          end else if ({2'b00, line_q} < ye_q) begin
            line_d = line_q + 8'd1;
            word_d = x_q[8:2];
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      frame_q <= 1'b0;
      xe_q    <= '0;
      ye_q    <= '0;
      line_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      frame_q <= frame_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      line_q  <= line_d;
      word_q  <= word_d;
    end
  end

  logic        in_write;
  logic [31:0] frame_base, word_addr;
  logic [3:0]  lane_en;
  logic [9:0]  px;

  always_comb begin
    in_write   = (state_q == S_WRITE);
    frame_base = frame_q ? (FB_BASE + FRAME_OFFSET) : FB_BASE;
    word_addr  = frame_base + (32'(line_q) * 32'(H_RES)) + {23'd0, word_q, 2'b00};
    lane_en    = 4'b0000;
    px         = '0;
    for (int k = 0; k < 4; k++) begin
      px         = {1'b0, word_q, 2'(k)};
      lane_en[k] = (px >= {1'b0, x_q}) && (px <= xe_q);
    end
  end

  // Bus outputs are driven only while a write is presented and read zero otherwise.
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign bus_write_enable = in_write;
  assign bus_request      = in_write;
  assign bus_address      = in_write ? word_addr : 32'd0;
  assign bus_write_data   = in_write ? {4{color_q}} : 32'd0;
  assign bus_byte_enable  = in_write ? lane_en : 4'b0000;

endmodule
